hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised successor to the 2-operand forwarding unit: per-source forwarding select for NUM_SRC operands,
//  plus load-use stall, multi-cycle-multiply scoreboard stall and branch-flush sequencer.
//  Sits beside the 5-stage pipeline, driving EX operand muxes, PC/IF-ID stall enables and IF-ID/ID-EX flushes.
// PARAMETERS
//  REG_AW        3  register address width (2**REG_AW architectural registers)
//  NUM_SRC       2  source operands per instruction (1..4)
//  MUL_LAT       3  cycles from mul_issue until result is forwardable from WB (1..7)
//  FLUSH_CYCLES  2  cycles flush_* is held after branch_taken_ex (1..7)
//  ZERO_REG_EN   0  1: register 0 is hard-wired, never forwarded or scoreboarded
// PORTS
//  clk            in   1               pipeline clock
//  reset          in   1               async, active-low; 0 = in reset
//  Rs_id          in   NUM_SRC*REG_AW  ID-stage source regs, operand i at [i*REG_AW +: REG_AW]
//  rs_used_id     in   NUM_SRC         operand i actually read by ID instruction
//  Rs_ex          in   NUM_SRC*REG_AW  EX-stage source regs (forwarding compare)
//  Rd_ex          in   REG_AW          EX destination
//  write_reg_ex   in   1               EX instruction writes Rd_ex
//  load_ex        in   1               EX instruction is a load
//  Rd_mem         in   REG_AW          MEM destination
//  write_reg_mem  in   1               MEM writes Rd_mem
//  Rd_wb          in   REG_AW          WB destination
//  write_reg_wb   in   1               WB writes Rd_wb
//  mul_issue      in   1               valid multi-cycle multiply leaves EX this cycle
//  Rd_mul         in   REG_AW          multiply destination
//  branch_taken_ex in  1               taken branch/jump resolved in EX
//  Fwd            out  NUM_SRC*3       one-hot select per operand: 001 MEM, 100 WB, 010 regfile
//  stall_pc       out  1               hold PC
//  stall_if_id    out  1               hold IF/ID register
//  bubble_id_ex   out  1               load NOP into ID/EX
//  flush_if_id    out  1               squash IF/ID
//  flush_id_ex    out  1               squash ID/EX
//  sb_busy        out  1               any scoreboard entry pending
// BEHAVIOUR
//  Reset (reset=0, async): Fwd all 010, every stall/flush/bubble 0, sb_busy 0, scoreboard cleared, FSM IDLE.
//  Forwarding (combinational, 0 latency), per operand i:
//   write_reg_mem & Rd_mem==Rs_ex[i] -> 001; else write_reg_wb & Rd_wb==Rs_ex[i] -> 100; else 010.
//   MEM beats WB when both match. ZERO_REG_EN=1 and Rs_ex[i]==0 -> 010 always.
//  Load-use: load_ex & write_reg_ex & any i (rs_used_id[i] & Rs_id[i]==Rd_ex) -> lu_stall (1 cycle each time).
//  Scoreboard: one counter per register, width clog2(MUL_LAT+1).
//   mul_issue (gated off when flush active) loads cnt[Rd_mul]=MUL_LAT at next edge; nonzero counters decrement by 1/cycle, stop at 0.
//   Issue and decrement same register same cycle -> issue value wins. sb_busy = OR(cnt!=0).
//   sb_stall = any i (rs_used_id[i] & cnt[Rs_id[i]]!=0). Register 0 never set when ZERO_REG_EN=1.
//  Stall outputs: stall_pc = stall_if_id = bubble_id_ex = (lu_stall | sb_stall) & ~flush_active.
//  Flush FSM states IDLE, FLUSH; down-counter fcnt:
//   IDLE: branch_taken_ex -> flush_active=1 this cycle; if FLUSH_CYCLES>1 go FLUSH, fcnt=FLUSH_CYCLES-1.
//   FLUSH: flush_active=1; fcnt decrements; fcnt==1 and no branch -> IDLE next edge.
//   branch_taken_ex while in FLUSH -> reload fcnt=FLUSH_CYCLES-1 (restart window).
//   flush_if_id = flush_id_ex = flush_active = branch_taken_ex | (state==FLUSH).
//  Flush has priority over every stall; scoreboard counters keep counting during flush/stall.
//  Reset asserted mid-flush or mid-multiply: immediate return to reset values, no residual stall.
// STRUCTURE
//  hazard_pkg: fwd_sel_t (FWD_MEM=3'b001, FWD_RF=3'b010, FWD_WB=3'b100), flush_state_t {IDLE,FLUSH}.
//  Sub-module hazard_scoreboard (counter array, set/decrement, per-operand pending lookup, sb_busy).
//  Top: forwarding compare generate-loop over NUM_SRC, load-use compare, flush FSM, output priority.
// TESTING (defaults unless stated)
//  1 Rs_ex=(3,5), MEM wr Rd=3, WB wr Rd=5 -> Fwd=(001,100); MEM and WB both Rd=3 -> op0 001; hold reset=0 -> 010,010.
//  2 load_ex, Rd_ex=4, Rs_id op1=4 used -> stall_pc/stall_if_id/bubble_id_ex=1 one cycle; same with rs_used_id[1]=0 -> 0.
//  3 mul_issue Rd_mul=6 at t0, Rs_id op0=6 used -> stall t1..t3, released t4; sb_busy 1 over t1..t3.
//  4 branch_taken_ex at t0 -> flush_* 1 at t0,t1, 0 at t2; second branch at t1 -> flush held through t2.
//  5 branch_taken_ex together with load-use hazard -> flush 1, stall/bubble 0; mul_issue in same cycle ignored.
//  6 reset pulled low at t1 after mul_issue at t0 -> all outputs default, sb_busy 0; ZERO_REG_EN=1 Rs_ex=0 MEM Rd=0 -> 010.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard control slice: forwarding select encoding and
// flush sequencer state encoding.
package hazard_pkg;

  typedef enum logic [2:0] {
    FWD_MEM = 3'b001,
    FWD_RF  = 3'b010,
    FWD_WB  = 3'b100
  } fwd_sel_t;

  // Legacy-compatible state encoding kept as plain constants.
  typedef logic [0:0] flush_state_t;
  localparam flush_state_t IDLE  = 1'b0;
  localparam flush_state_t FLUSH = 1'b1;

endpackage

// File: rtl/hazard_scoreboard.sv
// Multi-cycle multiply scoreboard: one down-counter per architectural register,
// per-operand pending lookup and an any-pending flag.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int NUM_SRC     = 2,
  parameter int MUL_LAT     = 3,
  parameter bit ZERO_REG_EN = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      set_en,
  input  logic [REG_AW-1:0]         set_reg,
  input  logic [NUM_SRC*REG_AW-1:0] rs,
  output logic [NUM_SRC-1:0]        pending,
  output logic                      busy
);

  localparam int NREG = 1 << REG_AW;
  localparam int CW   = $clog2(MUL_LAT + 1);

  logic [CW-1:0] cnt [NREG];
  logic          set_ok;

  assign set_ok = set_en && !(ZERO_REG_EN && (set_reg == '0));

  // NOTE: the counter array is reset explicitly; a stale count after reset
  // would raise a phantom stall, so this is state, not a RAM.
  // NOTE: non-blocking assignments keep every counter update reading the
  // pre-edge value, so all registers advance together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (set_ok && (set_reg == REG_AW'(r))) cnt[r] <= CW'(MUL_LAT);
        else if (cnt[r] != '0)                 cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < NREG; r++) busy = busy | (cnt[r] != '0);
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_pend
    assign pending[i] = (cnt[rs[i*REG_AW +: REG_AW]] != '0);
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control beside the 5-stage pipeline: EX operand forwarding selects,
// load-use and multiply-scoreboard stalls, and the taken-branch flush sequencer.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 3,
  parameter int NUM_SRC      = 2,
  parameter int MUL_LAT      = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter bit ZERO_REG_EN  = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] Rs_id,
  input  logic [NUM_SRC-1:0]        rs_used_id,
  input  logic [NUM_SRC*REG_AW-1:0] Rs_ex,
  input  logic [REG_AW-1:0]         Rd_ex,
  input  logic                      write_reg_ex,
  input  logic                      load_ex,
  input  logic [REG_AW-1:0]         Rd_mem,
  input  logic                      write_reg_mem,
  input  logic [REG_AW-1:0]         Rd_wb,
  input  logic                      write_reg_wb,
  input  logic                      mul_issue,
  input  logic [REG_AW-1:0]         Rd_mul,
  input  logic                      branch_taken_ex,
  output logic [NUM_SRC*3-1:0]      Fwd,
  output logic                      stall_pc,
  output logic                      stall_if_id,
  output logic                      bubble_id_ex,
  output logic                      flush_if_id,
  output logic                      flush_id_ex,
  output logic                      sb_busy
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCW-1:0] FC_RELOAD = FCW'(FLUSH_CYCLES - 1);

  logic [NUM_SRC-1:0] lu_hit;
  logic [NUM_SRC-1:0] sb_pend;
  logic               lu_stall;
  logic               sb_stall;
  logic               flush_active;
  logic               stall;
  flush_state_t       state;
  logic [FCW-1:0]     fcnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    logic [REG_AW-1:0] rs;
    fwd_sel_t          sel;

    assign rs = Rs_ex[i*REG_AW +: REG_AW];

    // NOTE: defaulting sel before the priority chain prevents a latch.
    always_comb begin
      sel = FWD_RF;
      if (!reset || (ZERO_REG_EN && (rs == '0))) sel = FWD_RF;
      else if (write_reg_mem && (Rd_mem == rs))  sel = FWD_MEM;
      else if (write_reg_wb && (Rd_wb == rs))    sel = FWD_WB;
    end

    assign Fwd[i*3 +: 3] = sel;
    assign lu_hit[i]     = rs_used_id[i] && (Rs_id[i*REG_AW +: REG_AW] == Rd_ex);
  end

  assign lu_stall = load_ex && write_reg_ex && (|lu_hit);
  assign sb_stall = |(sb_pend & rs_used_id);

  // Reset also masks the combinational paths so nothing leaks out while held.
  assign flush_active = reset && (branch_taken_ex || (state == FLUSH));
  assign stall        = reset && (lu_stall || sb_stall) && !flush_active;

  assign stall_pc     = stall;
  assign stall_if_id  = stall;
  assign bubble_id_ex = stall;
  assign flush_if_id  = flush_active;
  assign flush_id_ex  = flush_active;

  // A branch seen in FLUSH restarts the window rather than extending it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      fcnt  <= '0;
    end else if (state == IDLE) begin
      if (branch_taken_ex && (FLUSH_CYCLES > 1)) begin
        state <= FLUSH;
        fcnt  <= FC_RELOAD;
      end
    end else begin
      if (branch_taken_ex) begin
        fcnt <= FC_RELOAD;
      end else if (fcnt <= FCW'(1)) begin
        state <= IDLE;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt - 1'b1;
      end
    end
  end

  hazard_scoreboard #(
    .REG_AW     (REG_AW),
    .NUM_SRC    (NUM_SRC),
    .MUL_LAT    (MUL_LAT),
    .ZERO_REG_EN(ZERO_REG_EN)
  ) u_sb (
    .clk    (clk),
    .reset  (reset),
    .set_en (mul_issue && !flush_active),
    .set_reg(Rd_mul),
    .rs     (Rs_id),
    .pending(sb_pend),
    .busy   (sb_busy)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed vectors push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl_unit;

  localparam logic [2:0] M = 3'b001;
  localparam logic [2:0] R = 3'b010;
  localparam logic [2:0] W = 3'b100;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Rs_id, Rs_ex;
  logic [1:0] rs_used_id;
  logic [2:0] Rd_ex, Rd_mem, Rd_wb, Rd_mul;
  logic       write_reg_ex, load_ex, write_reg_mem, write_reg_wb, mul_issue, branch_taken_ex;

  logic [5:0] fwd, fwd_z;
  logic       stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex, sb_busy;
  logic       z_stall_pc, z_stall_if_id, z_bubble_id_ex, z_flush_if_id, z_flush_id_ex, z_sb_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [5:0] fwd;
    logic       stall;
    logic       flush;
    logic       busy;
    bit         chk_z;
    logic [5:0] fwd_z;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  hazard_ctrl_unit dut (
    .clk(clk), .reset(reset), .Rs_id(Rs_id), .rs_used_id(rs_used_id), .Rs_ex(Rs_ex),
    .Rd_ex(Rd_ex), .write_reg_ex(write_reg_ex), .load_ex(load_ex), .Rd_mem(Rd_mem),
    .write_reg_mem(write_reg_mem), .Rd_wb(Rd_wb), .write_reg_wb(write_reg_wb),
    .mul_issue(mul_issue), .Rd_mul(Rd_mul), .branch_taken_ex(branch_taken_ex),
    .Fwd(fwd), .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .sb_busy(sb_busy)
  );

  hazard_ctrl_unit #(.ZERO_REG_EN(1'b1)) dut_z (
    .clk(clk), .reset(reset), .Rs_id(Rs_id), .rs_used_id(rs_used_id), .Rs_ex(Rs_ex),
    .Rd_ex(Rd_ex), .write_reg_ex(write_reg_ex), .load_ex(load_ex), .Rd_mem(Rd_mem),
    .write_reg_mem(write_reg_mem), .Rd_wb(Rd_wb), .write_reg_wb(write_reg_wb),
    .mul_issue(mul_issue), .Rd_mul(Rd_mul), .branch_taken_ex(branch_taken_ex),
    .Fwd(fwd_z), .stall_pc(z_stall_pc), .stall_if_id(z_stall_if_id),
    .bubble_id_ex(z_bubble_id_ex), .flush_if_id(z_flush_if_id), .flush_id_ex(z_flush_id_ex),
    .sb_busy(z_sb_busy)
  );

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.name, " fwd"}, fwd, mon_e.fwd);
      check({mon_e.name, " stall_pc"}, {5'b0, stall_pc}, {5'b0, mon_e.stall});
      check({mon_e.name, " stall_if_id"}, {5'b0, stall_if_id}, {5'b0, mon_e.stall});
      check({mon_e.name, " bubble_id_ex"}, {5'b0, bubble_id_ex}, {5'b0, mon_e.stall});
      check({mon_e.name, " flush_if_id"}, {5'b0, flush_if_id}, {5'b0, mon_e.flush});
      check({mon_e.name, " flush_id_ex"}, {5'b0, flush_id_ex}, {5'b0, mon_e.flush});
      check({mon_e.name, " sb_busy"}, {5'b0, sb_busy}, {5'b0, mon_e.busy});
      if (mon_e.chk_z) check({mon_e.name, " fwd_z"}, fwd_z, mon_e.fwd_z);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic [5:0] f, input logic st,
                          input logic fl, input logic bz,
                          input bit cz = 1'b0, input logic [5:0] fz = 6'b0);
    exp_t e;
    e.name = nm; e.fwd = f; e.stall = st; e.flush = fl; e.busy = bz;
    e.chk_z = cz; e.fwd_z = fz;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    Rs_id = '0; rs_used_id = '0; Rs_ex = '0; Rd_ex = '0; Rd_mem = '0; Rd_wb = '0; Rd_mul = '0;
    write_reg_ex = 0; load_ex = 0; write_reg_mem = 0; write_reg_wb = 0;
    mul_issue = 0; branch_taken_ex = 0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();

    cyc(); push_exp("reset_idle", {R, R}, 0, 0, 0, 1, {R, R});
    cyc(); Rs_ex = {3'd5, 3'd3}; write_reg_mem = 1; Rd_mem = 3; write_reg_wb = 1; Rd_wb = 5;
    push_exp("reset_held_fwd", {R, R}, 0, 0, 0, 1, {R, R});

    // Forwarding
    cyc(); reset = 1'b1; push_exp("fwd_mem_wb", {W, M}, 0, 0, 0, 1, {W, M});
    cyc(); Rd_wb = 3; push_exp("fwd_mem_beats_wb", {R, M}, 0, 0, 0, 1, {R, M});
    cyc(); Rs_ex = {3'd3, 3'd3}; write_reg_mem = 0; push_exp("fwd_wb_only", {W, W}, 0, 0, 0, 1, {W, W});
    cyc(); clear_inputs(); Rs_ex = {3'd0, 3'd0}; write_reg_mem = 1; Rd_mem = 0;
    push_exp("fwd_reg0", {M, M}, 0, 0, 0, 1, {R, R});

    // Load-use
    cyc(); clear_inputs(); load_ex = 1; write_reg_ex = 1; Rd_ex = 4; Rs_id = {3'd4, 3'd1};
    rs_used_id = 2'b11; push_exp("lu_stall", {R, R}, 1, 0, 0);
    cyc(); load_ex = 0; push_exp("lu_released", {R, R}, 0, 0, 0);
    cyc(); load_ex = 1; rs_used_id = 2'b01; push_exp("lu_unused_op", {R, R}, 0, 0, 0);

    // Multiply scoreboard
    cyc(); clear_inputs(); Rs_id = {3'd0, 3'd6}; rs_used_id = 2'b01; mul_issue = 1; Rd_mul = 6;
    push_exp("mul_t0", {R, R}, 0, 0, 0);
    cyc(); mul_issue = 0; push_exp("mul_t1", {R, R}, 1, 0, 1);
    cyc(); push_exp("mul_t2", {R, R}, 1, 0, 1);
    cyc(); push_exp("mul_t3", {R, R}, 1, 0, 1);
    cyc(); push_exp("mul_t4", {R, R}, 0, 0, 0);

    // Re-issue while counting down: issue value wins
    cyc(); mul_issue = 1; push_exp("reiss_t0", {R, R}, 0, 0, 0);
    cyc(); mul_issue = 0; push_exp("reiss_t1", {R, R}, 1, 0, 1);
    cyc(); mul_issue = 1; push_exp("reiss_t2", {R, R}, 1, 0, 1);
    cyc(); mul_issue = 0; push_exp("reiss_t3", {R, R}, 1, 0, 1);
    cyc(); push_exp("reiss_t4", {R, R}, 1, 0, 1);
    cyc(); push_exp("reiss_t5", {R, R}, 1, 0, 1);
    cyc(); push_exp("reiss_t6", {R, R}, 0, 0, 0);

    // Flush sequencer
    cyc(); clear_inputs(); branch_taken_ex = 1; push_exp("br_t0", {R, R}, 0, 1, 0);
    cyc(); branch_taken_ex = 0; push_exp("br_t1", {R, R}, 0, 1, 0);
    cyc(); push_exp("br_t2", {R, R}, 0, 0, 0);
    cyc(); branch_taken_ex = 1; push_exp("br2_t0", {R, R}, 0, 1, 0);
    cyc(); push_exp("br2_t1", {R, R}, 0, 1, 0);
    cyc(); branch_taken_ex = 0; push_exp("br2_t2", {R, R}, 0, 1, 0);
    cyc(); push_exp("br2_t3", {R, R}, 0, 0, 0);

    // Flush priority over load-use, mul_issue dropped
    cyc(); branch_taken_ex = 1; load_ex = 1; write_reg_ex = 1; Rd_ex = 4; Rs_id = {3'd0, 3'd4};
    rs_used_id = 2'b01; mul_issue = 1; Rd_mul = 2; push_exp("prio_t0", {R, R}, 0, 1, 0);
    cyc(); clear_inputs(); Rs_id = {3'd0, 3'd2}; rs_used_id = 2'b01;
    push_exp("prio_t1", {R, R}, 0, 1, 0);
    cyc(); push_exp("prio_t2", {R, R}, 0, 0, 0);

    // Reset mid-multiply
    cyc(); clear_inputs(); Rs_id = {3'd0, 3'd6}; rs_used_id = 2'b01; mul_issue = 1; Rd_mul = 6;
    push_exp("rst_mul_t0", {R, R}, 0, 0, 0);
    cyc(); mul_issue = 0; reset = 1'b0; branch_taken_ex = 1;
    push_exp("rst_mul_t1", {R, R}, 0, 0, 0);
    cyc(); reset = 1'b1; branch_taken_ex = 0; push_exp("rst_mul_t2", {R, R}, 0, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
